wb_commit_stage: RTL and testbench
==================================

Name: wb_commit_stage

Overview:
- Writer side of the register-file write port that the decode stage reads through. Owns the MEM/WB pipeline register and drives `RegWrite`, `writeAddr` and `writeData`.
- Merges two result sources onto the single write port:
  - in-order scalar results (ALU or load) from the MEM stage;
  - out-of-order results from the SIMD/AES coprocessor, through a small commit FIFO.
- Gives decode the hazard flags and bypass data it needs to stay consistent with writes that are pending or in flight.

Parameters:
- `DEPTH`, 2, number of coprocessor commit-FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 4, cycles a FIFO head may wait behind pipeline writes before the block forces a pipeline hold.
- `DATA_W`, 64, register data width.

Ports:
- `clk` in 1 — clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `mem_valid` in 1 — MEM stage holds a valid instruction.
- `mem_RegWrite` in 1 — instruction writes a register.
- `mem_MemtoReg` in 1 — 1 selects load data, 0 selects ALU result.
- `mem_rd` in 5 — destination register.
- `mem_alu_result` in DATA_W — ALU result.
- `mem_load_data` in DATA_W — load data.
- `cp_valid` in 1 — coprocessor result offered.
- `cp_ready` out 1 — FIFO accepts the offered result.
- `cp_rd` in 5 — coprocessor destination register.
- `cp_data` in DATA_W — coprocessor result.
- `RegWrite` out 1 — register-file write enable (registered).
- `writeAddr` out 5 — write address (registered).
- `writeData` out DATA_W — write data (registered).
- `stall_req` out 1 — MEM stage must hold its current instruction this cycle.
- `id_rs1` in 5, `id_rs2` in 5, `id_rd` in 5 — decode-stage register fields.
- `hazard` out 1 — decode must stall: an id field matches a pending FIFO destination.
- `fwd1_en` out 1, `fwd1_data` out DATA_W — bypass for rs1 from the current write.
- `fwd2_en` out 1, `fwd2_data` out DATA_W — bypass for rs2 from the current write.

Behaviour:
- Reset (`rst` high at a rising edge):
  - `RegWrite`, `writeAddr`, `writeData` = 0.
  - FIFO emptied; starve counter = 0.
  - `stall_req` = 0, `hazard` = 0, `fwd*_en` = 0.
  - `cp_ready` = 0 while `rst` is high.
  - Reset mid-operation discards all FIFO contents and any in-flight write.
- Pipeline write request: `pw = mem_valid & mem_RegWrite & (mem_rd != 0)`.
- Commit at each rising edge, in priority order:
  1. If `stall_req` = 1: pop the FIFO head into the write registers. MEM inputs are ignored; MEM holds them and they are re-presented.
  2. Else if `pw` = 1: load the MEM result into the write registers, with data = `mem_MemtoReg` ? `mem_load_data` : `mem_alu_result`.
  3. Else if the FIFO is non-empty: pop the head.
  4. Else: `RegWrite` = 0. `writeAddr` and `writeData` keep their last values.
- Latency: a result is on the write port exactly 1 cycle after it is selected. `RegWrite` pulses for 1 cycle per commit.
- FIFO push: on `cp_valid & cp_ready`, only when `cp_rd != 0`. A coprocessor result addressed to x0 is accepted (handshake completes) and dropped.
- `cp_ready = !full & !rst`. This depends only on registered occupancy, not on a same-cycle pop.
- Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
- FIFO pointers wrap modulo DEPTH.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and rule 2 wins.
  - Clears on any pop.
  - Saturates at `STARVE_LIMIT`.
- `stall_req = full | (starve_cnt == STARVE_LIMIT)`. It is combinational from registered state and is never asserted while the FIFO is empty.
- `hazard` = 1 when any valid FIFO entry's rd is nonzero and equals `id_rs1`, `id_rs2` or `id_rd`. This covers RAW and WAW against coprocessor results.
- Forwarding (combinational):
  - `fwd1_en = RegWrite & (writeAddr == id_rs1) & (id_rs1 != 0)`, with `fwd1_data = writeData`.
  - `fwd2_en` and `fwd2_data` are the same, using `id_rs2`.
- Ordering: scalar results commit in program order. The coprocessor path commits in FIFO order. Cross-path ordering is guaranteed by decode honouring `hazard`.

Decomposition:
- Shared package `wb_pkg`:
  - typedef `wb_entry_t` {logic [4:0] rd; logic [DATA_W-1:0] data;};
  - constant `REG_ZERO` = 5'd0.
- One sub-module: `commit_fifo`, parameterized by DEPTH. It provides push/pop/full/empty and exposes its entry rd fields and valid bits for the hazard compare.
- Arbitration, starve counter, write registers and forwarding stay in the top module.

Test Plan:
1. Reset: hold `rst` 3 cycles with `cp_valid` = 1 → all outputs 0 and `cp_ready` = 0; 1 cycle after release, `cp_ready` = 1.
2. Scalar commit at cycle N: `mem_rd` = 5, ALU = 0x1234, `MemtoReg` = 0 → cycle N+1: `RegWrite` = 1, `writeAddr` = 5, `writeData` = 0x1234. Repeat with `MemtoReg` = 1, load = 0xDEAD → `writeData` = 0xDEAD. With `id_rs1` = 5: `fwd1_en` = 1, `fwd1_data` = 0xDEAD.
3. x0 suppression: scalar write to rd 0 → `RegWrite` stays 0. Coprocessor push to rd 0 → handshake completes, no commit, `hazard` stays 0.
4. Idle-slot drain: pipeline idle; push `cp_rd` = 7, data 0xAA → `hazard` = 1 for `id_rs2` = 7 for 1 cycle; next cycle `RegWrite` = 1, `writeAddr` = 7, `writeData` = 0xAA; then `hazard` = 0.
5. Contention: `pw` every cycle; push rd 3, then rd 4 → `cp_ready` falls when full and `stall_req` = 1. Rd 3 commits, then rd 4 (after at most `STARVE_LIMIT` cycles). Held MEM results commit afterwards with no loss or duplication.
6. Reset with FIFO full and `stall_req` = 1 → next cycle FIFO empty, `stall_req` = 0, no further commits of the old entries.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback commit stage.
package wb_pkg;

  localparam int DATA_W = 64;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/commit_fifo.sv
// Small circular FIFO holding coprocessor results waiting for a free write-port slot.
// Entry rd fields and valid bits are exported so decode can check them for hazards.
module commit_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEPTH-1:0][4:0] entry_rd
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; the valid bits and occupancy alone say which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Pointers are AW bits wide, so the increment wraps modulo DEPTH on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr              <= rd_ptr + 1'b1;
        entry_valid[rd_ptr] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr              <= wr_ptr + 1'b1;
        entry_valid[wr_ptr] <= 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_rd[i] = mem[i].rd;
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Register-file write port owner: arbitrates scalar MEM results against queued
// coprocessor results, and supplies decode with hazard and bypass information.
module wb_commit_stage #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic              mem_MemtoReg,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic              cp_valid,
  output logic              cp_ready,
  input  logic [4:0]        cp_rd,
  input  logic [DATA_W-1:0] cp_data,
  output logic              RegWrite,
  output logic [4:0]        writeAddr,
  output logic [DATA_W-1:0] writeData,
  output logic              stall_req,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  output logic              hazard,
  output logic              fwd1_en,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_en,
  output logic [DATA_W-1:0] fwd2_data
);

  import wb_pkg::*;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic                  pw;
  logic                  cp_push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  wb_entry_t             head;
  wb_entry_t             push_entry;
  logic [DEPTH-1:0]      entry_valid;
  logic [DEPTH-1:0][4:0] entry_rd;
  logic [SW-1:0]         starve_cnt;
  logic [DATA_W-1:0]     mem_data;

  assign pw         = mem_valid & mem_RegWrite & (mem_rd != REG_ZERO);
  assign mem_data   = mem_MemtoReg ? mem_load_data : mem_alu_result;
  assign cp_ready   = ~full & ~rst;
  // x0 results complete the handshake but never enter the FIFO.
  assign cp_push    = cp_valid & cp_ready & (cp_rd != REG_ZERO);
  assign push_entry = '{rd: cp_rd, data: cp_data};
  assign stall_req  = ~empty & (full | (starve_cnt == STARVE_MAX));
  assign pop        = stall_req | (~pw & ~empty);

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (cp_push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // Commit priority: forced FIFO drain, then scalar result, then idle-slot drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite   <= 1'b0;
      writeAddr  <= REG_ZERO;
      writeData  <= '0;
      starve_cnt <= '0;
    end else begin
      if (pop) begin
        RegWrite  <= 1'b1;
        writeAddr <= head.rd;
        writeData <= head.data;
      end else if (pw) begin
        RegWrite  <= 1'b1;
        writeAddr <= mem_rd;
        writeData <= mem_data;
      end else begin
        RegWrite  <= 1'b0;
      end

      if (pop)
        starve_cnt <= '0;
      else if (pw && !empty && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // NOTE: default assignment first so the loop below can never infer a latch.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entry_rd[i] != REG_ZERO &&
          (entry_rd[i] == id_rs1 || entry_rd[i] == id_rs2 || entry_rd[i] == id_rd))
        hazard = 1'b1;
    end
  end

  assign fwd1_en   = RegWrite & (writeAddr == id_rs1) & (id_rs1 != REG_ZERO);
  assign fwd1_data = writeData;
  assign fwd2_en   = RegWrite & (writeAddr == id_rs2) & (id_rs2 != REG_ZERO);
  assign fwd2_data = writeData;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_wb_commit_stage;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int DATA_W       = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_valid = 1'b0, mem_RegWrite = 1'b0, mem_MemtoReg = 1'b0;
  logic [4:0]        mem_rd = '0;
  logic [DATA_W-1:0] mem_alu_result = '0, mem_load_data = '0;
  logic              cp_valid = 1'b0;
  logic              cp_ready;
  logic [4:0]        cp_rd = '0;
  logic [DATA_W-1:0] cp_data = '0;
  logic              RegWrite;
  logic [4:0]        writeAddr;
  logic [DATA_W-1:0] writeData;
  logic              stall_req;
  logic [4:0]        id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic              hazard;
  logic              fwd1_en, fwd2_en;
  logic [DATA_W-1:0] fwd1_data, fwd2_data;

  always #5 clk = ~clk;

  wb_commit_stage #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
    .mem_rd(mem_rd), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .cp_valid(cp_valid), .cp_ready(cp_ready), .cp_rd(cp_rd), .cp_data(cp_data),
    .RegWrite(RegWrite), .writeAddr(writeAddr), .writeData(writeData),
    .stall_req(stall_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .hazard(hazard),
    .fwd1_en(fwd1_en), .fwd1_data(fwd1_data),
    .fwd2_en(fwd2_en), .fwd2_data(fwd2_data)
  );

  // Reference model: pending coprocessor results as a plain queue plus the write port.
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t        q[$];
  int          m_starve = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [63:0] m_data = '0;
  logic [4:0]  commit_log[$];
  bit          last_stall = 1'b0, last_accept = 1'b0, last_ready = 1'b0;
  int          n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: mid-cycle combinational checks, model step, registered checks after the edge.
  task automatic tick();
    bit   e_ready, e_stall, e_haz, e_f1, e_f2, pw, push;
    ent_t h;
    @(negedge clk);
    e_ready = !rst && (q.size() < DEPTH);
    e_stall = 1'b0;
    check("cp_ready", cp_ready, e_ready);
    if (!rst) begin
      e_stall = (q.size() == DEPTH) || (m_starve >= STARVE_LIMIT);
      e_haz = 1'b0;
      foreach (q[i])
        if (q[i].rd == id_rs1 || q[i].rd == id_rs2 || q[i].rd == id_rd) e_haz = 1'b1;
      e_f1 = m_we && m_addr == id_rs1 && id_rs1 != 0;
      e_f2 = m_we && m_addr == id_rs2 && id_rs2 != 0;
      check("stall_req", stall_req, e_stall);
      check("hazard", hazard, e_haz);
      check("fwd1_en", fwd1_en, e_f1);
      check("fwd2_en", fwd2_en, e_f2);
      if (e_f1) check("fwd1_data", fwd1_data, m_data);
      if (e_f2) check("fwd2_data", fwd2_data, m_data);
    end
    last_stall  = e_stall;
    last_ready  = e_ready;
    last_accept = cp_valid && e_ready;
    if (rst) begin
      q.delete();
      m_starve = 0;
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      pw   = mem_valid && mem_RegWrite && mem_rd != 0;
      push = cp_valid && e_ready && cp_rd != 0;
      if (e_stall || (!pw && q.size() > 0)) begin
        h = q.pop_front();
        m_we = 1'b1;
        m_addr = h.rd;
        m_data = h.data;
        m_starve = 0;
      end else if (pw) begin
        m_we = 1'b1;
        m_addr = mem_rd;
        m_data = mem_MemtoReg ? mem_load_data : mem_alu_result;
        if (q.size() > 0 && m_starve < STARVE_LIMIT) m_starve++;
      end else begin
        m_we = 1'b0;
      end
      if (push) q.push_back(ent_t'{cp_rd, cp_data});
      if (m_we) commit_log.push_back(m_addr);
    end
    @(posedge clk);
    #1;
    check("RegWrite", RegWrite, m_we);
    check("writeAddr", writeAddr, m_addr);
    check("writeData", writeData, m_data);
  endtask

  initial begin
    int sc, pos3, pos4, n_scalar;
    bit saw_stall, saw_notready;

    // Reset held three cycles with a coprocessor offer pending.
    rst = 1'b1;
    cp_valid = 1'b1;
    cp_rd = 5'd9;
    cp_data = 64'h55;
    repeat (3) tick();
    check("rst_RegWrite", RegWrite, 1'b0);
    check("rst_stall", stall_req, 1'b0);
    check("rst_hazard", hazard, 1'b0);
    rst = 1'b0;
    cp_valid = 1'b0;
    tick();
    check("ready_after_rst", cp_ready, 1'b1);

    // Scalar commits, ALU then load, with rs1 bypass.
    mem_valid = 1'b1; mem_RegWrite = 1'b1; mem_MemtoReg = 1'b0;
    mem_rd = 5'd5; mem_alu_result = 64'h1234; mem_load_data = 64'h9999;
    tick();
    check("alu_we", RegWrite, 1'b1);
    check("alu_addr", writeAddr, 5'd5);
    check("alu_data", writeData, 64'h1234);
    mem_MemtoReg = 1'b1; mem_load_data = 64'hDEAD;
    tick();
    id_rs1 = 5'd5;
    #1;
    check("load_data", writeData, 64'hDEAD);
    check("fwd1_en_5", fwd1_en, 1'b1);
    check("fwd1_data_5", fwd1_data, 64'hDEAD);

    // x0 writes from both sources are suppressed.
    mem_rd = 5'd0;
    tick();
    check("x0_scalar", RegWrite, 1'b0);
    mem_valid = 1'b0;
    id_rs1 = 5'd0;
    cp_valid = 1'b1; cp_rd = 5'd0; cp_data = 64'h77;
    check("x0_cp_ready", cp_ready, 1'b1);
    tick();
    cp_valid = 1'b0;
    tick();
    check("x0_cp_no_commit", RegWrite, 1'b0);
    check("x0_cp_no_hazard", hazard, 1'b0);

    // Idle-slot drain of a single coprocessor result.
    cp_valid = 1'b1; cp_rd = 5'd7; cp_data = 64'hAA; id_rs2 = 5'd7;
    tick();
    cp_valid = 1'b0;
    #1;
    check("drain_hazard", hazard, 1'b1);
    tick();
    check("drain_we", RegWrite, 1'b1);
    check("drain_addr", writeAddr, 5'd7);
    check("drain_data", writeData, 64'hAA);
    check("drain_hazard_clr", hazard, 1'b0);
    id_rs2 = 5'd0;

    // Contention: pipeline writes every cycle while two coprocessor results queue up.
    commit_log.delete();
    sc = 0; saw_stall = 1'b0; saw_notready = 1'b0; last_stall = 1'b0;
    cp_valid = 1'b1; cp_rd = 5'd3; cp_data = 64'h333;
    mem_valid = 1'b1; mem_RegWrite = 1'b1; mem_MemtoReg = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (!last_stall) begin
        mem_rd = 5'(16 + sc % 15);
        mem_alu_result = 64'(sc + 100);
      end
      tick();
      if (!last_stall) sc++;
      saw_stall    |= last_stall;
      saw_notready |= !last_ready;
      if (last_accept) begin
        if (cp_rd == 5'd3) begin
          cp_rd = 5'd4;
          cp_data = 64'h444;
        end else begin
          cp_valid = 1'b0;
        end
      end
    end
    mem_valid = 1'b0;
    repeat (3) tick();
    pos3 = -1; pos4 = -1; n_scalar = 0;
    foreach (commit_log[i]) begin
      if (commit_log[i] == 5'd3 && pos3 < 0) pos3 = i;
      if (commit_log[i] == 5'd4 && pos4 < 0) pos4 = i;
      if (commit_log[i] >= 5'd16) n_scalar++;
    end
    check("cont_saw_stall", saw_stall, 1'b1);
    check("cont_saw_notready", saw_notready, 1'b1);
    check("cont_cp_order", (pos3 >= 0 && pos4 > pos3), 1'b1);
    check("cont_scalar_count", n_scalar, sc);

    // Reset while the FIFO is full and stalling the pipeline.
    mem_valid = 1'b1; mem_rd = 5'd20; mem_alu_result = 64'h20;
    cp_valid = 1'b1; cp_rd = 5'd9; cp_data = 64'h99;
    tick();
    cp_rd = 5'd10; cp_data = 64'h1010;
    tick();
    cp_valid = 1'b0;
    #1;
    check("full_stall_pre", stall_req, 1'b1);
    rst = 1'b1;
    commit_log.delete();
    tick();
    rst = 1'b0;
    mem_valid = 1'b0;
    id_rs1 = 5'd9;
    #1;
    check("post_rst_stall", stall_req, 1'b0);
    check("post_rst_hazard", hazard, 1'b0);
    check("post_rst_we", RegWrite, 1'b0);
    repeat (3) tick();
    check("post_rst_no_commit", commit_log.size(), 0);
    id_rs1 = 5'd0;

    // Random traffic against the reference model.
    last_stall = 1'b0; last_accept = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!last_stall) begin
        mem_valid      = ($urandom_range(0, 3) != 0);
        mem_RegWrite   = ($urandom_range(0, 4) != 0);
        mem_MemtoReg   = $urandom_range(0, 1);
        mem_rd         = 5'($urandom_range(0, 7));
        mem_alu_result = {$urandom, $urandom};
        mem_load_data  = {$urandom, $urandom};
      end
      if (!cp_valid || last_accept) begin
        cp_valid = ($urandom_range(0, 2) == 0);
        cp_rd    = 5'($urandom_range(0, 7));
        cp_data  = {$urandom, $urandom};
      end
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      id_rd  = 5'($urandom_range(0, 7));
      rst    = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
